router_output_arbiter: RTL and testbench
========================================

// Module: router_output_arbiter
// PURPOSE
//  Per-output-port packet scheduler for the credit-based mesh router. Shares one output
//  channel among NPORTS input buffers with round-robin fairness. Holds a grant for a whole
//  wormhole packet: header flit, size flit, then `size` payload flits.
//  One instance sits in front of each router output (E/W/N/S/Local) and drives tx/data_out.
// PARAMETERS
//  NPORTS      5   number of requesting input buffers (E,W,N,S,Local = idx 0..4)
//  FLIT_WIDTH  16  flit width in bits; the size flit is interpreted as unsigned FLIT_WIDTH
// PORTS
//  clock    in   1                   single clock; all state changes on posedge
//  reset    in   1                   synchronous, active-high
//  req_i    in   NPORTS              req_i[i]=1: buffer i presents a valid flit on data_i[i]
//  data_i   in   NPORTS*FLIT_WIDTH   flit from buffer i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
//  ack_o    out  NPORTS              one-hot or zero; flit on data_i[i] consumed this cycle
//  credit_i in   1                   downstream can accept a flit this cycle
//  tx_o     out  1                   flit valid on data_o this cycle
//  data_o   out  FLIT_WIDTH          flit to downstream router/NI
//  grant_o  out  NPORTS              one-hot owner of the channel; 0 when idle
//  busy_o   out  1                   packet in flight (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, grant_o=0, rr pointer=0, counter=0. Outputs ack_o=0, tx_o=0,
//   data_o=0, busy_o=0 during reset and in the cycle after.
//  FSM states: IDLE -> HEADER -> SIZE -> PAYLOAD -> IDLE.
//   IDLE: if any req_i, pick the winner by round-robin starting at the pointer.
//    Register a one-hot grant and go to HEADER. No flit moves in IDLE (1-cycle arbitration).
//   HEADER: on transfer, go to SIZE.
//   SIZE: on transfer, load cnt=data flit. If data==0, go to IDLE; else go to PAYLOAD.
//   PAYLOAD: on transfer, cnt--. If cnt==1 at that transfer, go to IDLE.
//  Transfer (combinational, same cycle) = state!=IDLE & req_i[g] & credit_i, where g=grant.
//   On transfer: ack_o[g]=1, tx_o=1, data_o=data_i[g].
//   Otherwise: ack_o=0, tx_o=0, data_o=0.
//  Stalls: credit_i=0 or req_i[g]=0 holds state, cnt and grant. Other requesters are ignored
//   until the packet completes (no preemption).
//  Pointer: updated only when a grant is issued; ptr = (winner+1) mod NPORTS.
//   Wrap from NPORTS-1 to 0.
//  After the last flit, grant_o clears in the next cycle. Arbitrating the next packet costs
//   one bubble cycle, so the minimum gap between packets is 1 idle cycle on tx_o.
//  A req_i that drops in IDLE before the grant is registered is not granted.
//   A req_i that drops after the grant stalls the packet.
//  Maximum payload = 2^FLIT_WIDTH-1 flits. The counter is FLIT_WIDTH bits wide and never
//   wraps below 0.
//  Reset asserted mid-packet aborts it: IDLE, grant 0, pointer 0. Recovering the partially
//   sent flits is the upstream's concern.
// STRUCTURE
//  router_pkg:
//   - typedef logic [FLIT_WIDTH-1:0] flit_t
//   - typedef enum {IDLE,HEADER,SIZE,PAYLOAD} arb_state_t
//   - localparam NPORTS_DEFAULT=5
//   - port index constants EAST..LOCAL
//  Sub-module rr_arbiter #(N): req vector + pointer -> one-hot winner, purely combinational.
//   The pointer register lives in router_output_arbiter.
//  Top contains the FSM, size counter, grant register and output mux.
// TESTING
//  1. req_i=00001, packet {0x0102, 0x0003, A,B,C}, credit_i=1 ->
//     grant_o=00001 one cycle later; tx_o high 5 consecutive cycles; data_o=0102,0003,A,B,C;
//     then IDLE and grant_o=0.
//  2. req_i=10011 held, each buffer sending 1-payload packets ->
//     grant order 0,1,4,0,1,4; one bubble between packets.
//  3. Size flit=0x0000 -> exactly 2 flits sent; busy_o falls the cycle after the size flit.
//  4. credit_i low 3 cycles mid-payload -> tx_o=0 and ack_o=0 for those 3 cycles;
//     cnt holds; the remaining flits follow in order with no loss or duplication.
//  5. Granted req_i drops 2 cycles mid-packet while port 2 requests ->
//     grant stays on the owner; no ack to port 2 until the owner's packet completes.
//  6. reset=1 during PAYLOAD with ptr=3 -> next cycle grant_o=0, tx_o=0, busy_o=0;
//     after release, simultaneous req_i=11111 grants port 0 first.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the mesh router output arbiter.
package router_pkg;

  localparam int NPORTS_DEFAULT     = 5;
  localparam int FLIT_WIDTH_DEFAULT = 16;

  // Input buffer indices as seen by every output arbiter
  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;

  typedef logic [FLIT_WIDTH_DEFAULT-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } arb_state_t;

  // Round-robin successor of idx among n ports, wrapping n-1 back to 0
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]                   req,
  input  logic [$clog2(N > 1 ? N : 2)-1:0] ptr,
  output logic [N-1:0]                   gnt
);

  int   idx;
  logic found;

  // Scan the request vector circularly starting at the pointer
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Output-port packet scheduler: round-robin arbitration, grant held for a
// whole wormhole packet (header, size, then `size` payload flits).
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int NPORTS     = NPORTS_DEFAULT,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            req_i,
  input  logic [NPORTS*FLIT_WIDTH-1:0] data_i,
  output logic [NPORTS-1:0]            ack_o,
  input  logic                         credit_i,
  output logic                         tx_o,
  output logic [FLIT_WIDTH-1:0]        data_o,
  output logic [NPORTS-1:0]            grant_o,
  output logic                         busy_o
);

  localparam int PW = $clog2(NPORTS > 1 ? NPORTS : 2);

  // Payload counter decrement that sticks at zero instead of wrapping
  function automatic logic [FLIT_WIDTH-1:0] sat_dec(input logic [FLIT_WIDTH-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  arb_state_t            state;
  logic [NPORTS-1:0]     grant;
  logic [PW-1:0]         ptr;
  logic [FLIT_WIDTH-1:0] cnt;

  logic [NPORTS-1:0]     win;
  logic [PW-1:0]         ptr_nxt;
  logic [FLIT_WIDTH-1:0] sel_data;
  logic                  sel_req;
  logic                  xfer;

  rr_arbiter #(.N(NPORTS)) u_rr (
    .req (req_i),
    .ptr (ptr),
    .gnt (win)
  );

  // Route the granted buffer's request and flit onto the output side
  always_comb begin
    sel_data = '0;
    sel_req  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | data_i[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_req  = sel_req | req_i[i];
      end
    end
  end

  // Pointer value to store if the current arbitration winner is granted
  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win[i]) ptr_nxt = PW'(rr_next(i, NPORTS));
    end
  end

  // A flit moves only while a packet owns the channel, the owner has a
  // flit and downstream has a credit; reset suppresses any movement.
  assign xfer    = (state != IDLE) && sel_req && credit_i && !reset;
  assign ack_o   = xfer ? grant : '0;
  assign tx_o    = xfer;
  assign data_o  = xfer ? sel_data : '0;
  assign grant_o = grant;
  assign busy_o  = (state != IDLE) && !reset;

  // Packet FSM: arbitrate in IDLE, then walk header/size/payload on transfers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            grant <= win;
            ptr   <= ptr_nxt;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state <= SIZE;
        end
        SIZE: begin
          if (xfer) begin
            cnt <= sel_data;
            if (sel_data == '0) begin
              state <= IDLE;
              grant <= '0;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            cnt <= sat_dec(cnt);
            if (cnt == {{(FLIT_WIDTH-1){1'b0}}, 1'b1}) begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: table vectors, directed corner sequences
// and randomized traffic against a packet-level reference model.
module tb_router_output_arbiter;
  import router_pkg::*;

  localparam int NP = 5;
  localparam int FW = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic [NP-1:0]      req_i;
  logic [NP*FW-1:0]   data_i;
  logic [NP-1:0]      ack_o;
  logic               credit_i;
  logic               tx_o;
  logic [FW-1:0]      data_o;
  logic [NP-1:0]      grant_o;
  logic               busy_o;

  router_output_arbiter #(.NPORTS(NP), .FLIT_WIDTH(FW)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_i    (req_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .credit_i (credit_i),
    .tx_o     (tx_o),
    .data_o   (data_o),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NP-1:0] req;
    logic [FW-1:0] d0;
    logic          cr;
    logic          tx;
    logic [FW-1:0] dout;
    logic [NP-1:0] gnt;
    logic [NP-1:0] ack;
    logic          busy;
  } vec_t;

  vec_t tbl[11];

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus state: per-port flit queues held as arrays
  bit            use_q;
  bit            drv_en[NP];
  logic          cr_drv, rst_drv;
  logic [FW-1:0] mem[NP][16];
  int            head[NP];
  int            len[NP];

  // sampled outputs and logs
  logic          s_tx, s_busy;
  logic [FW-1:0] s_data;
  logic [NP-1:0] s_grant, s_ack, prev_grant;
  logic [FW-1:0] cap_data[64];
  int            cap_port[64];
  int            ncap;
  int            glog[16];
  int            nglog;
  logic          tr[128];
  int            ntr;

  // reference model: owner port, flits sent in packet, packet length once known
  int            m_owner, m_sent, m_total, m_ptr;
  bit            m_xfer;
  logic [FW-1:0] m_xdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < NP; i++) begin
      head[i] = 0;
      len[i]  = 0;
      drv_en[i] = 1'b1;
    end
  endtask

  task automatic load_pkt(input int p, input logic [FW-1:0] hdr, input int size);
    mem[p][len[p]] = hdr;       len[p]++;
    mem[p][len[p]] = FW'(size); len[p]++;
    for (int k = 0; k < size; k++) begin
      mem[p][len[p]] = hdr + FW'(k + 1);
      len[p]++;
    end
  endtask

  // One clock: drive inputs, compare against model at negedge, advance at posedge
  task automatic step();
    logic [NP-1:0] e_grant, e_ack;
    logic          e_tx, e_busy;
    logic [FW-1:0] e_data;
    bit            found;
    int            c;
    reset    = rst_drv;
    credit_i = cr_drv;
    if (use_q) begin
      for (int i = 0; i < NP; i++) begin
        req_i[i] = drv_en[i] && (head[i] < len[i]);
        data_i[i*FW +: FW] = (head[i] < len[i]) ? mem[i][head[i]] : FW'($urandom);
      end
    end
    @(negedge clock);
    e_grant = (m_owner >= 0) ? (5'b1 << m_owner) : '0;
    e_ack = '0; e_tx = 1'b0; e_data = '0; e_busy = 1'b0; m_xfer = 1'b0;
    if (!reset && m_owner >= 0) begin
      e_busy = 1'b1;
      if (req_i[m_owner] && credit_i) begin
        m_xfer  = 1'b1;
        e_tx    = 1'b1;
        e_ack   = 5'b1 << m_owner;
        e_data  = data_i[m_owner*FW +: FW];
        m_xdata = e_data;
      end
    end
    s_tx = tx_o; s_data = data_o; s_grant = grant_o; s_ack = ack_o; s_busy = busy_o;
    check("tx",    32'(s_tx),    32'(e_tx));
    check("data",  32'(s_data),  32'(e_data));
    check("grant", 32'(s_grant), 32'(e_grant));
    check("ack",   32'(s_ack),   32'(e_ack));
    check("busy",  32'(s_busy),  32'(e_busy));
    if (s_tx && ncap < 64) begin
      cap_data[ncap] = s_data;
      cap_port[ncap] = oh2idx(s_grant);
      ncap++;
    end
    if (s_grant != '0 && prev_grant == '0 && nglog < 16) begin
      glog[nglog] = oh2idx(s_grant);
      nglog++;
    end
    prev_grant = s_grant;
    if (ntr < 128) begin
      tr[ntr] = s_tx;
      ntr++;
    end
    @(posedge clock);
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        c = (m_ptr + k) % NP;
        if (!found && req_i[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_ptr   = (c + 1) % NP;
          m_sent  = 0;
          m_total = -1;
        end
      end
    end else if (m_xfer) begin
      if (m_sent == 1) m_total = 2 + int'(m_xdata);
      m_sent++;
      if (m_total >= 0 && m_sent == m_total) m_owner = -1;
    end
    if (use_q) begin
      for (int i = 0; i < NP; i++) begin
        if (s_ack[i] && head[i] < len[i]) head[i]++;
        if (rst_drv) head[i] = len[i];
      end
    end
    #1;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_until_cap(input string nm, input int n, input int budget);
    int b;
    b = budget;
    while (ncap < n && b > 0) begin
      step();
      b--;
    end
    check(nm, 32'(ncap), 32'(n));
  endtask

  task automatic do_reset();
    clear_q();
    use_q   = 1'b1;
    cr_drv  = 1'b1;
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    ncap = 0; nglog = 0; ntr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[6];
    int first, last;
    exp2 = '{0, 1, 4, 0, 1, 4};

    tbl[0]  = '{5'b00001, 16'h0102, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 1'b0};
    tbl[1]  = '{5'b00001, 16'h0102, 1'b1, 1'b1, 16'h0102, 5'b00001, 5'b00001, 1'b1};
    tbl[2]  = '{5'b00001, 16'h0003, 1'b1, 1'b1, 16'h0003, 5'b00001, 5'b00001, 1'b1};
    tbl[3]  = '{5'b00001, 16'h00A0, 1'b1, 1'b1, 16'h00A0, 5'b00001, 5'b00001, 1'b1};
    tbl[4]  = '{5'b00001, 16'h00B0, 1'b1, 1'b1, 16'h00B0, 5'b00001, 5'b00001, 1'b1};
    tbl[5]  = '{5'b00001, 16'h00C0, 1'b1, 1'b1, 16'h00C0, 5'b00001, 5'b00001, 1'b1};
    tbl[6]  = '{5'b00000, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 1'b0};
    tbl[7]  = '{5'b00001, 16'h1111, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 1'b0};
    tbl[8]  = '{5'b00001, 16'h1111, 1'b1, 1'b1, 16'h1111, 5'b00001, 5'b00001, 1'b1};
    tbl[9]  = '{5'b00001, 16'h0000, 1'b1, 1'b1, 16'h0000, 5'b00001, 5'b00001, 1'b1};
    tbl[10] = '{5'b00000, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 1'b0};

    reset = 1'b1; req_i = '0; data_i = '0; credit_i = 1'b0;
    m_owner = -1; m_ptr = 0; m_sent = 0; m_total = -1; m_xdata = '0;
    prev_grant = '0; ncap = 0; nglog = 0; ntr = 0;
    clear_q();
    repeat (2) @(posedge clock);
    #1;

    // reset state: the cycle after reset everything is quiet
    use_q = 1'b1; cr_drv = 1'b1; rst_drv = 1'b0;
    step();
    check("rst_grant", 32'(s_grant), 32'h0);
    check("rst_tx",    32'(s_tx),    32'h0);
    check("rst_busy",  32'(s_busy),  32'h0);
    check("rst_ack",   32'(s_ack),   32'h0);
    check("rst_data",  32'(s_data),  32'h0);

    // single packet {0102,0003,A,B,C} then a zero-size packet
    use_q = 1'b0;
    for (int r = 0; r < 11; r++) begin
      req_i  = tbl[r].req;
      data_i = {64'h0, tbl[r].d0};
      cr_drv = tbl[r].cr;
      step();
      check($sformatf("tbl%0d_tx", r),    32'(s_tx),    32'(tbl[r].tx));
      check($sformatf("tbl%0d_data", r),  32'(s_data),  32'(tbl[r].dout));
      check($sformatf("tbl%0d_grant", r), 32'(s_grant), 32'(tbl[r].gnt));
      check($sformatf("tbl%0d_ack", r),   32'(s_ack),   32'(tbl[r].ack));
      check($sformatf("tbl%0d_busy", r),  32'(s_busy),  32'(tbl[r].busy));
    end

    // round robin among ports 0,1,4 with two 1-payload packets each
    do_reset();
    for (int p = 0; p < NP; p++) begin
      if (p == 0 || p == 1 || p == 4) begin
        load_pkt(p, FW'(16'h2000 + p * 16'h0100), 1);
        load_pkt(p, FW'(16'h2800 + p * 16'h0100), 1);
      end
    end
    run_n(30);
    check("rr_count", 32'(nglog), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("rr_order%0d", k), 32'(glog[k]), 32'(exp2[k]));
    check("rr_flits", 32'(ncap), 32'd18);
    first = -1; last = -1;
    for (int k = 0; k < ntr; k++) begin
      if (tr[k]) begin
        if (first < 0) first = k;
        last = k;
      end
    end
    check("rr_span", 32'(last - first + 1), 32'd23);

    // credit withdrawn for 3 cycles mid-payload
    do_reset();
    load_pkt(0, 16'h4000, 5);
    run_until_cap("cr_reach", 4, 20);
    cr_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("cr_stall_tx%0d", k),    32'(s_tx),    32'h0);
      check($sformatf("cr_stall_ack%0d", k),   32'(s_ack),   32'h0);
      check($sformatf("cr_stall_grant%0d", k), 32'(s_grant), 32'h1);
    end
    cr_drv = 1'b1;
    run_n(8);
    check("cr_total", 32'(ncap), 32'd7);
    for (int k = 0; k < 7; k++) check($sformatf("cr_flit%0d", k), 32'(cap_data[k]), 32'(mem[0][k]));

    // owner drops its request while port 2 waits
    do_reset();
    load_pkt(0, 16'h5000, 4);
    load_pkt(2, 16'h5200, 1);
    run_until_cap("drop_reach", 3, 20);
    drv_en[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("drop_grant%0d", k), 32'(s_grant), 32'h1);
      check($sformatf("drop_ack%0d", k),   32'(s_ack),   32'h0);
    end
    drv_en[0] = 1'b1;
    run_n(15);
    check("drop_total", 32'(ncap), 32'd9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("drop_port%0d", k), 32'(cap_port[k]), (k < 6) ? 32'd0 : 32'd2);
      check($sformatf("drop_flit%0d", k), 32'(cap_data[k]), (k < 6) ? 32'(mem[0][k]) : 32'(mem[2][k-6]));
    end

    // reset during payload with the pointer at 3
    do_reset();
    load_pkt(2, 16'h6200, 4);
    run_until_cap("rstmid_reach", 4, 20);
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    check("rstmid_grant", 32'(s_grant), 32'h0);
    check("rstmid_tx",    32'(s_tx),    32'h0);
    check("rstmid_busy",  32'(s_busy),  32'h0);
    clear_q();
    for (int p = 0; p < NP; p++) load_pkt(p, FW'(16'h6000 + p * 16'h0010), 0);
    nglog = 0;
    step();
    step();
    check("rstmid_first", 32'(s_grant), 32'h1);
    run_n(20);
    check("rstmid_count", 32'(nglog), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("rstmid_order%0d", k), 32'(glog[k]), 32'(k));

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (head[i] >= len[i] && $urandom_range(2, 0) == 0) begin
          head[i] = 0;
          len[i]  = 0;
          load_pkt(i, FW'($urandom), int'($urandom_range(3, 0)));
        end
        drv_en[i] = ($urandom_range(3, 0) != 0);
      end
      cr_drv  = ($urandom_range(4, 0) != 0);
      rst_drv = ($urandom_range(249, 0) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
